// File: rtl/mac_feeder_l6_pkg.sv
// Shared types for the layer-6 MAC feeder: FSM encoding, pipe tag layout and lane width.
package mac_feeder_l6_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/mac_feeder_l6_tag_delay.sv
// Carries {valid, first, last} tags from the address stage down to the accumulator input
// and derives A/B gating, load_sig, skip fetch timing and out_valid from them.
module tag_delay_l6
  import mac_feeder_l6_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  input  logic i_first,
  input  logic i_last,
  output logic o_ab_vld,
  output logic o_load,
  output logic o_skip_pre,
  output logic o_out_vld,
  output logic o_empty
);

  tag_t w_tag;
  tag_t r_tag_p [PIPE_LAT+1];
  logic r_out_vld;

  assign w_tag = '{vld: i_vld, first: i_first, last: i_last};

  // p0 is aligned with A/B; p[PIPE_LAT] is aligned with the accumulator input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= PIPE_LAT; i++) r_tag_p[i] <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_tag_p[0] <= w_tag;
      for (int i = 1; i <= PIPE_LAT; i++) r_tag_p[i] <= r_tag_p[i-1];
      r_out_vld <= r_tag_p[PIPE_LAT].vld & r_tag_p[PIPE_LAT].last;
    end
  end

  assign o_ab_vld   = r_tag_p[0].vld;
  assign o_load     = r_tag_p[PIPE_LAT].vld & r_tag_p[PIPE_LAT].first;
  assign o_skip_pre = r_tag_p[PIPE_LAT].vld & r_tag_p[PIPE_LAT].last;
  assign o_out_vld  = r_out_vld;

  always_comb begin
    o_empty = 1'b1;
    for (int i = 0; i <= PIPE_LAT; i++) begin
      if (r_tag_p[i].vld) o_empty = 1'b0;
    end
  end

endmodule

// File: rtl/mac_feeder_l6.sv
// Layer-6 MAC feeder: walks pixels x channel groups, drives activation/weight/skip buffer
// addresses and presents aligned A/B lanes, load_sig and out_valid to the adder tree.
module mac_feeder_l6
  import mac_feeder_l6_pkg::*;
#(
  parameter int N        = 4,
  parameter int NGRP     = 4,
  parameter int AW       = 10,
  parameter int WAW      = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     num_out,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     act_addr,
  input  logic [DW*N-1:0]   act_data,
  output logic [WAW-1:0]    wgt_addr,
  input  logic [DW*N-1:0]   wgt_data,
  output logic [DW*N-1:0]   A,
  output logic [DW*N-1:0]   B,
  output logic              load_sig,
  output logic [AW-1:0]     skip_addr,
  input  logic [DW-1:0]     skip_data,
  output logic [DW-1:0]     in_skip,
  output logic              out_valid
);

  localparam int GW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

  fsm_t          r_state;
  logic [AW-1:0] r_num_out;
  logic [AW-1:0] r_pix;
  logic [GW-1:0] r_grp;
  logic [AW-1:0] r_act_addr;
  logic [AW-1:0] r_skip_addr;
  logic          r_busy;
  logic          r_done;

  logic w_issue;
  logic w_grp_first;
  logic w_grp_last;
  logic w_pix_last;
  logic w_frame_go;
  logic w_ab_vld;
  logic w_load;
  logic w_skip_pre;
  logic w_out_vld;
  logic w_pipe_empty;

  assign w_issue     = (r_state == ST_ISSUE);
  assign w_grp_first = (r_grp == '0);
  assign w_grp_last  = (r_grp == GRP_LAST);
  assign w_pix_last  = (r_pix == r_num_out - AW'(1));
  assign w_frame_go  = (r_state == ST_IDLE) && start && (num_out != '0);

  // The counters themselves are the issued address, so the first address lands one cycle after start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_num_out  <= '0;
      r_pix      <= '0;
      r_grp      <= '0;
      r_act_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (num_out == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_ISSUE;
              r_num_out  <= num_out;
              r_pix      <= '0;
              r_grp      <= '0;
              r_act_addr <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (w_grp_last && w_pix_last) begin
            r_state <= ST_DRAIN;
          end else begin
            r_act_addr <= r_act_addr + AW'(1);
            if (w_grp_last) begin
              r_grp <= '0;
              r_pix <= r_pix + AW'(1);
            end else begin
              r_grp <= r_grp + GW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Skip address advances as each pixel's residual is fetched, one cycle ahead of out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skip_addr <= '0;
    end else if (w_frame_go) begin
      r_skip_addr <= '0;
    end else if (w_skip_pre) begin
      r_skip_addr <= r_skip_addr + AW'(1);
    end
  end

  tag_delay_l6 #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag_delay (
    .clk        (clk),
    .rst        (rst),
    .i_vld      (w_issue),
    .i_first    (w_grp_first),
    .i_last     (w_grp_last),
    .o_ab_vld   (w_ab_vld),
    .o_load     (w_load),
    .o_skip_pre (w_skip_pre),
    .o_out_vld  (w_out_vld),
    .o_empty    (w_pipe_empty)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign act_addr  = r_act_addr;
  assign wgt_addr  = WAW'(r_grp);
  assign skip_addr = r_skip_addr;
  assign load_sig  = w_load;
  assign out_valid = w_out_vld;
  assign A         = w_ab_vld  ? act_data  : '0;
  assign B         = w_ab_vld  ? wgt_data  : '0;
  assign in_skip   = w_out_vld ? skip_data : '0;

endmodule

// File: tb/tb_mac_feeder_l6.sv
// Directed bench for mac_feeder_l6: one NGRP=4 and one NGRP=1 instance with modelled buffers.
module tb_mac_feeder_l6;

  localparam int AW  = 10;
  localparam int WAW = 6;

  typedef struct {
    bit u1;
    int g;
    int s;
    int num;
    int first_load;
    int first_valid;
    int done_c;
    int busy_lo;
    int busy_hi;
  } vec_t;

  typedef struct {
    logic           busy;
    logic           done;
    logic           ld;
    logic           ov;
    logic [AW-1:0]  aa;
    logic [AW-1:0]  sa;
    logic [WAW-1:0] wa;
    logic [63:0]    a;
    logic [63:0]    b;
    logic [15:0]    is;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s4 = 1'b0, s1 = 1'b0;
  logic [AW-1:0] n4 = '0, n1 = '0;
  logic busy4, done4, ld4, ov4, busy1, done1, ld1, ov1;
  logic [AW-1:0] aa4, sa4, aa1, sa1;
  logic [WAW-1:0] wa4, wa1;
  logic [63:0] ad4, wd4, A4, B4, ad1, wd1, A1, B1;
  logic [15:0] sd4, is4, sd1, is1;

  int total = 0;
  int bad = 0;

  function automatic logic [63:0] act_val(input int a);
    return {16'hA000 ^ 16'(a), 16'hB100 ^ 16'(a), 16'hC200 ^ 16'(a), 16'hD300 ^ 16'(a)};
  endfunction

  function automatic logic [63:0] wgt_val(input int g);
    return {16'h1100 + 16'(g), 16'h2200 + 16'(g), 16'h3300 + 16'(g), 16'h4400 + 16'(g)};
  endfunction

  function automatic logic [15:0] skip_val(input int p);
    return 16'h7000 + 16'(p * 3);
  endfunction

  always @(posedge clk) begin
    ad4 <= act_val(int'(aa4));
    wd4 <= wgt_val(int'(wa4));
    sd4 <= skip_val(int'(sa4));
    ad1 <= act_val(int'(aa1));
    wd1 <= wgt_val(int'(wa1));
    sd1 <= skip_val(int'(sa1));
  end

  mac_feeder_l6 #(.N(4), .NGRP(4), .AW(AW), .WAW(WAW), .PIPE_LAT(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(s4), .num_out(n4), .busy(busy4), .done(done4),
    .act_addr(aa4), .act_data(ad4), .wgt_addr(wa4), .wgt_data(wd4), .A(A4), .B(B4),
    .load_sig(ld4), .skip_addr(sa4), .skip_data(sd4), .in_skip(is4), .out_valid(ov4)
  );

  mac_feeder_l6 #(.N(4), .NGRP(1), .AW(AW), .WAW(WAW), .PIPE_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .num_out(n1), .busy(busy1), .done(done1),
    .act_addr(aa1), .act_data(ad1), .wgt_addr(wa1), .wgt_data(wd1), .A(A1), .B(B1),
    .load_sig(ld1), .skip_addr(sa1), .skip_data(sd1), .in_skip(is1), .out_valid(ov1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
    end
  endtask

  function automatic obs_t sample(input bit u1);
    obs_t o;
    if (u1) begin
      o = '{busy1, done1, ld1, ov1, aa1, sa1, wa1, A1, B1, is1};
    end else begin
      o = '{busy4, done4, ld4, ov4, aa4, sa4, wa4, A4, B4, is4};
    end
    return o;
  endfunction

  task automatic drive(input bit u1, input logic st, input logic [AW-1:0] num);
    if (u1) begin
      s1 = st;
      n1 = num;
    end else begin
      s4 = st;
      n4 = num;
    end
  endtask

  task automatic check_cycle(input vec_t v, input int t, input obs_t o);
    logic e_ld, e_ov;
    int vp, sp, k;
    logic [63:0] ea, eb;
    e_ld = 1'b0;
    e_ov = 1'b0;
    vp = -1;
    sp = -1;
    for (int p = 0; p < v.num; p++) begin
      if (t == v.first_load + p * v.g) e_ld = 1'b1;
      if (t == v.first_valid + p * v.g) begin
        e_ov = 1'b1;
        vp = p;
      end
      if (t == v.first_valid + p * v.g - 1) sp = p;
    end
    chk("load_sig", t, 64'(o.ld), 64'(e_ld));
    chk("out_valid", t, 64'(o.ov), 64'(e_ov));
    chk("busy", t, 64'(o.busy), 64'(t >= v.busy_lo && t <= v.busy_hi));
    chk("done", t, 64'(o.done), 64'(t == v.done_c));
    k = t - v.s - 2;
    if (v.num > 0 && k >= 0 && k < v.g * v.num) begin
      ea = act_val(k);
      eb = wgt_val(k % v.g);
    end else begin
      ea = '0;
      eb = '0;
    end
    chk("A", t, o.a, ea);
    chk("B", t, o.b, eb);
    k = t - v.s - 1;
    if (v.num > 0 && k >= 0 && k < v.g * v.num) begin
      chk("act_addr", t, 64'(o.aa), 64'(k));
      chk("wgt_addr", t, 64'(o.wa), 64'(k % v.g));
    end
    if (sp >= 0) chk("skip_addr", t, 64'(o.sa), 64'(sp));
    chk("in_skip", t, 64'(o.is), (vp >= 0) ? 64'(skip_val(vp)) : 64'(0));
  endtask

  vec_t vecs [5];
  vec_t v;
  int cnt_ld, cnt_ov, done_t, first_ld, n_done_pre;

  initial begin
    // {u1, NGRP, start, num_out, first load, first valid, done, busy from, busy to}
    vecs[0] = '{0, 4, 10, 3, 14, 18, 27, 11, 27};
    vecs[1] = '{1, 1,  0, 5,  4,  5, 10,  1, 10};
    vecs[2] = '{0, 4,  5, 0, -1, -1,  6,  6,  6};
    vecs[3] = '{0, 4,  3, 1,  7, 11, 12,  4, 12};
    vecs[4] = '{1, 1,  2, 2,  6,  7,  9,  3,  9};

    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("rst_busy", t, 64'(busy4), 64'(0));
      chk("rst_done", t, 64'(done4), 64'(0));
      chk("rst_load", t, 64'(ld4), 64'(0));
      chk("rst_valid", t, 64'(ov4), 64'(0));
      chk("rst_act_addr", t, 64'(aa4), 64'(0));
      chk("rst_wgt_addr", t, 64'(wa4), 64'(0));
      chk("rst_skip_addr", t, 64'(sa4), 64'(0));
      chk("rst_A", t, A4, 64'(0));
      chk("rst_B", t, B4, 64'(0));
      chk("rst_in_skip", t, 64'(is4), 64'(0));
      chk("rst_busy1", t, 64'(busy1), 64'(0));
      chk("rst_valid1", t, 64'(ov1), 64'(0));
    end
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("idle_busy", t, 64'(busy4), 64'(0));
      chk("idle_load", t, 64'(ld4), 64'(0));
      chk("idle_valid", t, 64'(ov4), 64'(0));
      chk("idle_done", t, 64'(done4), 64'(0));
      chk("idle_A", t, A4, 64'(0));
      chk("idle_load1", t, 64'(ld1), 64'(0));
    end

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      for (int t = 0; t <= v.done_c + 3; t++) begin
        check_cycle(v, t, sample(v.u1));
        drive(v.u1, t == v.s, (t == v.s) ? AW'(v.num) : '0);
        tick();
      end
    end

    // start presented again mid-frame with a different count must not restart the frame
    cnt_ld = 0;
    cnt_ov = 0;
    done_t = -1;
    for (int t = 0; t <= 22; t++) begin
      if (ld4) cnt_ld++;
      if (ov4) cnt_ov++;
      if (done4 && done_t < 0) done_t = t;
      if (t == 18) chk("ign_busy_after", t, 64'(busy4), 64'(0));
      drive(0, t == 2 || t == 6, (t == 2) ? AW'(2) : (t == 6) ? AW'(7) : '0);
      tick();
    end
    chk("ign_nload", 0, 64'(cnt_ld), 64'(2));
    chk("ign_nvalid", 0, 64'(cnt_ov), 64'(2));
    chk("ign_done_t", 0, 64'(done_t), 64'(15));

    // reset in the middle of a frame, then restart
    first_ld = -1;
    done_t = -1;
    n_done_pre = 0;
    for (int t = 0; t <= 40; t++) begin
      if (done4 && t < 20) n_done_pre++;
      if (ld4 && t >= 20 && first_ld < 0) first_ld = t;
      if (done4 && t >= 20 && done_t < 0) done_t = t;
      if (t == 14) chk("midrst_pre_load", t, 64'(ld4), 64'(1));
      if (t == 16) begin
        chk("midrst_pre_A", t, A4, act_val(4));
        rst = 1'b1;
        #1;
        chk("midrst_busy", t, 64'(busy4), 64'(0));
        chk("midrst_A", t, A4, 64'(0));
        chk("midrst_act_addr", t, 64'(aa4), 64'(0));
        chk("midrst_valid", t, 64'(ov4), 64'(0));
      end
      if (t == 18) rst = 1'b0;
      drive(0, t == 10 || t == 20, (t == 10 || t == 20) ? AW'(3) : '0);
      tick();
    end
    chk("midrst_no_done", 0, 64'(n_done_pre), 64'(0));
    chk("restart_load", 0, 64'(first_ld), 64'(24));
    chk("restart_done", 0, 64'(done_t), 64'(37));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
